mix_column_ctrl: RTL and testbench

Sequencer for the byte-serial `mix_column` datapath. It accepts a 16-byte AES state column-major over a valid/ready byte stream and buffers each column. Each buffered column is fed to `mix_column` as four back-to-back bytes using `mix_column`'s en protocol. The four result bytes are captured and streamed out over a second valid/ready port. On the final AES round it bypasses mixing. It sits between the ShiftRows byte stream and AddRoundKey in the low-area round loop.

---
 rtl/aes_ctrl_pkg.sv | 6 +
 rtl/mix_column_ctrl_if.sv | 21 ++
 rtl/mix_column_ctrl_col_buf.sv | 21 ++
 rtl/mix_column_ctrl.sv | 86 ++++++++
 tb/tb_mix_column_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types and constants for the AES round-loop controllers
package aes_ctrl_pkg;
  localparam int BYTES_PER_COL = 4;
  localparam int NCOL_DEFAULT = 4;
  typedef enum logic [2:0] {IDLE, LOAD, FEED, CAPT, DRAIN} state_t;
endpackage

// File: rtl/mix_column_ctrl_if.sv
// mix_column_ctrl_if: control, input byte stream and output byte stream of mix_column_ctrl
interface mix_column_ctrl_if;
  logic start;
  logic last_round;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic out_valid;
  logic [7:0] out_data;
  logic out_ready;
  logic busy;
  logic done;
  modport master (
    output start, last_round, in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, busy, done
  );
  modport slave (
    input start, last_round, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/mix_column_ctrl_col_buf.sv
// col_buf: 4x8 column buffer; byte write, parallel load (ldata[7:0] lands in row 0), byte read
module col_buf
  import aes_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic load,
  input  logic [BYTES_PER_COL*8-1:0] ldata,
  input  logic [1:0] raddr,
  output logic [7:0] rdata
);
  logic [BYTES_PER_COL-1:0][7:0] mem;
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem <= '0;
    else if (load) mem <= ldata;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mix_column_ctrl.sv
// mix_column_ctrl: buffers AES state columns, feeds them byte-serially to mix_column and streams the results out
module mix_column_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NCOL = NCOL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  mix_column_ctrl_if.slave s,
  output logic [7:0] mc_din,
  output logic mc_en,
  input  logic [7:0] mc_d0,
  input  logic [7:0] mc_d1,
  input  logic [7:0] mc_d2,
  input  logic [7:0] mc_d3
);
  localparam int CW = NCOL > 1 ? $clog2(NCOL) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);
  state_t state;
  logic [1:0] byte_cnt;
  logic [CW-1:0] col_cnt;
  logic bypass;
  logic done_q;
  logic [7:0] rd;
  logic last_byte;
  assign last_byte = &byte_cnt;
  col_buf u_buf (
    .clk(clk),
    .rst(rst),
    .we(state == LOAD && s.in_valid),
    .waddr(byte_cnt),
    .wdata(s.in_data),
    .load(state == CAPT),
    .ldata({mc_d3, mc_d2, mc_d1, mc_d0}),
    .raddr(byte_cnt),
    .rdata(rd)
  );
  // a start landing in the done cycle is dropped so each state yields exactly one done
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      byte_cnt <= '0;
      col_cnt <= '0;
      bypass <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (s.start && !done_q) begin
          state <= LOAD;
          bypass <= s.last_round;
          col_cnt <= '0;
          byte_cnt <= '0;
        end
        LOAD: if (s.in_valid) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (last_byte) state <= bypass ? DRAIN : FEED;
        end
        FEED: begin
          byte_cnt <= byte_cnt + 2'd1;
          if (last_byte) state <= CAPT;
        end
        CAPT: state <= DRAIN;
        DRAIN: if (s.out_ready) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (last_byte) begin
            if (col_cnt == LAST_COL) begin
              done_q <= 1'b1;
              state <= IDLE;
            end else begin
              col_cnt <= col_cnt + CW'(1);
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  assign s.in_ready = state == LOAD;
  assign s.out_valid = state == DRAIN;
  assign s.out_data = state == DRAIN ? rd : 8'h00;
  assign s.busy = state != IDLE;
  assign s.done = done_q;
  assign mc_en = state == FEED && byte_cnt != 2'd0;
  assign mc_din = state == FEED ? rd : 8'h00;
endmodule

// File: tb/tb_mix_column_ctrl.sv
// tb_mix_column_ctrl: directed bench with a MixColumns reference model and per-cycle output checker
module tb_mix_column_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mix_column_ctrl_if ifc ();
  logic [7:0] mc_din, mc_d0, mc_d1, mc_d2, mc_d3;
  logic mc_en;
  mix_column_ctrl dut (
    .clk(clk), .rst(rst), .s(ifc), .mc_din(mc_din), .mc_en(mc_en),
    .mc_d0(mc_d0), .mc_d1(mc_d1), .mc_d2(mc_d2), .mc_d3(mc_d3)
  );
  int vectors = 0;
  int miscompares = 0;
  int stall_pct = 0;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  // byte-serial mix_column: en=0 starts a column, result valid once four bytes are in
  logic [7:0] mcol [4] = '{default: 8'h00};
  logic [1:0] mi = 2'd0;
  always @(posedge clk)
    if (!mc_en) begin
      mcol[0] <= mc_din;
      mi <= 2'd1;
    end else begin
      mcol[mi] <= mc_din;
      mi <= mi + 2'd1;
    end
  assign {mc_d0, mc_d1, mc_d2, mc_d3} = mixcol({mcol[0], mcol[1], mcol[2], mcol[3]});
  logic [7:0] stim [16];
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  logic [7:0] ref_obs [$];
  int cyc = 0, busy_cyc, done_cnt, en_cnt, run = 0, in_cnt, out_cnt, t_in0 = 0, t_out4 = 0;
  logic [3:0] en_seq;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      run = 0;
      prev_stall = 1'b0;
    end else begin
      if (ifc.busy) busy_cyc++;
      if (ifc.done) done_cnt++;
      if (mc_en) begin
        en_cnt++;
        run++;
      end else if (run != 0) begin
        chk("feed_run_len", 32'(run), 32'd3);
        run = 0;
      end
      if (in_cnt >= 1 && (cyc - t_in0) inside {[4:7]}) en_seq = {en_seq[2:0], mc_en};
      if (ifc.in_valid && ifc.in_ready) begin
        if (in_cnt == 0) t_in0 = cyc;
        in_cnt++;
      end
      if (!ifc.busy)
        chk("idle_outputs", 32'({ifc.in_ready, ifc.out_valid, mc_en, mc_din, ifc.out_data}), 32'd0);
      if (prev_stall) chk("stall_hold", 32'({ifc.out_valid, ifc.out_data}), 32'({1'b1, prev_data}));
      if (ifc.out_valid && ifc.out_ready) begin
        out_cnt++;
        if (out_cnt == 4) t_out4 = cyc;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got %0h, want no output", ifc.out_data);
        end else chk("out_data", 32'(ifc.out_data), 32'(exp_q.pop_front()));
        obs_q.push_back(ifc.out_data);
      end
      prev_stall = ifc.out_valid && !ifc.out_ready;
      prev_data = ifc.out_data;
    end
  end
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 ifc.out_ready = $urandom_range(99) >= stall_pct;
    end
  end
  task automatic noise_step(input bit en);
    if (en) begin
      ifc.start = 1'($urandom_range(1));
      ifc.last_round = 1'($urandom_range(1));
    end
  endtask
  task automatic load_stim(input logic [127:0] v);
    for (int i = 0; i < 16; i++) stim[i] = v[127 - 8*i -: 8];
  endtask
  task automatic begin_state(input bit lr, input int nbytes, input int gap_pct, input bit noise);
    logic [31:0] r;
    busy_cyc = 0; done_cnt = 0; en_cnt = 0; in_cnt = 0; out_cnt = 0; en_seq = '0;
    obs_q.delete();
    for (int c = 0; c < 4; c++) begin
      r = mixcol({stim[4*c], stim[4*c+1], stim[4*c+2], stim[4*c+3]});
      for (int k = 0; k < 4; k++) exp_q.push_back(lr ? stim[4*c+k] : r[31 - 8*k -: 8]);
    end
    ifc.start = 1'b1;
    ifc.last_round = lr;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    ifc.last_round = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      int to;
      bit acc;
      to = 0;
      while ($urandom_range(99) < gap_pct) begin
        ifc.in_valid = 1'b0;
        noise_step(noise);
        @(posedge clk);
        #1;
      end
      do begin
        ifc.in_valid = 1'b1;
        ifc.in_data = stim[i];
        acc = ifc.in_ready;
        noise_step(noise);
        @(posedge clk);
        #1 to++;
      end while (!acc && to < 500);
      if (!acc) chk("in_accept_timeout", 32'(i), 32'hffff_ffff);
    end
    ifc.in_valid = 1'b0;
    ifc.in_data = 8'h00;
  endtask
  task automatic finish_state(input bit noise, input bit poke);
    int to = 0;
    while (!ifc.done && to < 2000) begin
      noise_step(noise);
      @(posedge clk);
      #1 to++;
    end
    if (to >= 2000) chk("done_timeout", 32'(to), 32'd0);
    ifc.start = poke;
    ifc.last_round = 1'b0;
    @(posedge clk);
    #1 ifc.start = 1'b0;
    chk("start_in_done_ignored", 32'(ifc.busy), 32'd0);
    chk("all_outputs_seen", 32'(exp_q.size()), 32'd0);
    chk("done_pulses", 32'(done_cnt), 32'd1);
  endtask
  logic [31:0] lit_out [4] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8};
  initial begin
    ifc.start = 1'b0;
    ifc.last_round = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data = 8'h00;
    chk("model_col0", mixcol(32'hdb135345), 32'h8e4da1bc);
    chk("model_col1", mixcol(32'hf20a225c), 32'h9fdc589d);
    chk("model_col3", mixcol(32'h2d26314c), 32'h4d7ebdf8);
    chk("model_c6", mixcol(32'hc6c6c6c6), 32'hc6c6c6c6);
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 32'({ifc.in_ready, ifc.out_valid, ifc.out_data, ifc.busy, ifc.done, mc_en, mc_din}), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 load_stim(128'hdb135345_f20a225c_01010101_2d26314c);
    begin_state(1'b0, 16, 0, 1'b0);
    finish_state(1'b0, 1'b0);
    chk("busy_cycles", 32'(busy_cyc), 32'd52);
    chk("mc_en_count", 32'(en_cnt), 32'd12);
    chk("col_latency", 32'(t_out4 - t_in0 + 1), 32'd13);
    chk("mc_en_seq", 32'(en_seq), 32'b0111);
    chk("out_count", 32'(obs_q.size()), 32'd16);
    for (int w = 0; w < 4; w++)
      chk("state_out_word", {obs_q[4*w], obs_q[4*w+1], obs_q[4*w+2], obs_q[4*w+3]}, lit_out[w]);
    ref_obs = obs_q;
    begin_state(1'b1, 16, 0, 1'b0);
    finish_state(1'b0, 1'b0);
    chk("bypass_busy_cycles", 32'(busy_cyc), 32'd32);
    chk("bypass_mc_en_count", 32'(en_cnt), 32'd0);
    for (int i = 0; i < 16; i++) chk("bypass_byte", 32'(obs_q[i]), 32'(stim[i]));
    stall_pct = 50;
    begin_state(1'b0, 16, 50, 1'b1);
    finish_state(1'b1, 1'b1);
    chk("stall_out_count", 32'(obs_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("stall_vs_nostall", 32'(obs_q[i]), 32'(ref_obs[i]));
    stall_pct = 0;
    @(posedge clk);
    #1 begin_state(1'b0, 12, 0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("abort_outputs", 32'({ifc.in_ready, ifc.out_valid, ifc.out_data, ifc.busy, ifc.done, mc_en, mc_din}), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    load_stim({16{8'hc6}});
    begin_state(1'b0, 16, 0, 1'b0);
    finish_state(1'b0, 1'b0);
    chk("restart_busy_cycles", 32'(busy_cyc), 32'd52);
    for (int i = 0; i < 16; i++) chk("restart_byte", 32'(obs_q[i]), 32'hc6);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
